// File: rtl/spi_frame_arbiter_if.sv
// Bundle of SPI-host frame signals and per-client TX/RX handshakes for spi_frame_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface spi_frame_arbiter_if;
   logic           HOST_DATA_READ;
   logic           HOST_DATA_WRITE;
   logic [255:0]   HOST_DATA_OUT;
   logic [255:0]   HOST_DATA_IN;
   logic [3:0]     TX_REQ;
   logic [991:0]   TX_DATA;
   logic [3:0]     TX_ACK;
   logic [3:0]     RX_READY;
   logic [3:0]     RX_VALID;
   logic [247:0]   RX_DATA;
   logic           BUSY;
   logic [7:0]     DROP_CNT;

   modport slave (
      input  HOST_DATA_READ, HOST_DATA_WRITE, HOST_DATA_OUT, TX_REQ, TX_DATA, RX_READY,
      output HOST_DATA_IN, TX_ACK, RX_VALID, RX_DATA, BUSY, DROP_CNT
   );

   modport master (
      output HOST_DATA_READ, HOST_DATA_WRITE, HOST_DATA_OUT, TX_REQ, TX_DATA, RX_READY,
      input  HOST_DATA_IN, TX_ACK, RX_VALID, RX_DATA, BUSY, DROP_CNT
   );
endinterface

// File: rtl/spi_frame_arbiter.sv
// Shares the SPI host's 256-bit frame path between 4 clients: round-robin TX staging with a
// post-read hold window, and header-addressed RX routing with a saturating drop counter.
module spi_frame_arbiter #(
   parameter int unsigned HOLD_CYCLES = 64
) (
   input logic                CLK,
   input logic                RESET_N,
   spi_frame_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StStaged, StHold} state_e;

   localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES);

   state_e         state_q, state_d;
   logic [1:0]     ptr_q, ptr_d;
   logic [1:0]     client_q, client_d;
   logic [7:0]     hold_cnt_q, hold_cnt_d;
   logic           empty_q, empty_d;
   logic [255:0]   data_in_q, data_in_d;
   logic [3:0]     rx_valid_q, rx_valid_d;
   logic [247:0]   rx_data_q, rx_data_d;
   logic [7:0]     drop_cnt_q, drop_cnt_d;
   logic           grant_vld;
   logic [1:0]     grant_idx;
   logic           ack_now;
   logic [1:0]     rx_id;

   // First requester at or after the pointer; the 2-bit add wraps modulo 4.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = ptr_q;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!grant_vld && bus.TX_REQ[ptr_q + 2'(i)]) begin
            grant_vld = 1'b1;
            grant_idx = ptr_q + 2'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      client_d   = client_q;
      hold_cnt_d = hold_cnt_q;
      empty_d    = empty_q;
      data_in_d  = data_in_q;
      unique case (state_q)
         StIdle: begin
            if (bus.HOST_DATA_READ) begin
               state_d    = StHold;
               empty_d    = 1'b1;
               hold_cnt_d = HoldLoad;
            end else if (grant_vld) begin
               state_d   = StStaged;
               client_d  = grant_idx;
               data_in_d = {bus.TX_DATA[32'(grant_idx) * 248 +: 248], 1'b1, 5'b0, grant_idx};
            end
         end
         StStaged: begin
            if (bus.HOST_DATA_READ) begin
               state_d    = StHold;
               empty_d    = 1'b0;
               hold_cnt_d = HoldLoad;
            end
         end
         StHold: begin
            hold_cnt_d = hold_cnt_q - 8'd1;
            if (hold_cnt_q <= 8'd1) begin
               state_d    = StIdle;
               hold_cnt_d = 8'd0;
               data_in_d  = '0;
               if (!empty_q) begin
                  ptr_d = client_q + 2'd1;
               end
            end
         end
         default: begin
            state_d   = StIdle;
            data_in_d = '0;
         end
      endcase
   end

   // RX routing runs every cycle regardless of the TX state.
   assign rx_id = bus.HOST_DATA_OUT[1:0];

   always_comb begin
      rx_valid_d = 4'b0000;
      rx_data_d  = rx_data_q;
      drop_cnt_d = drop_cnt_q;
      if (bus.HOST_DATA_WRITE && bus.HOST_DATA_OUT[7]) begin
         if (bus.RX_READY[rx_id]) begin
            rx_valid_d = 4'(4'b0001 << rx_id);
            rx_data_d  = bus.HOST_DATA_OUT[255:8];
         end else if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= StIdle;
         ptr_q      <= 2'd0;
         client_q   <= 2'd0;
         hold_cnt_q <= 8'd0;
         empty_q    <= 1'b0;
         data_in_q  <= '0;
         rx_valid_q <= 4'b0000;
         rx_data_q  <= '0;
         drop_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         client_q   <= client_d;
         hold_cnt_q <= hold_cnt_d;
         empty_q    <= empty_d;
         data_in_q  <= data_in_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ack_now          = (state_q == StHold) && (hold_cnt_q <= 8'd1) && !empty_q;
   assign bus.TX_ACK       = ack_now ? 4'(4'b0001 << client_q) : 4'b0000;
   assign bus.HOST_DATA_IN = data_in_q;
   assign bus.RX_VALID     = rx_valid_q;
   assign bus.RX_DATA      = rx_data_q;
   assign bus.BUSY         = (state_q != StIdle);
   assign bus.DROP_CNT     = drop_cnt_q;
endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Self-checking bench for spi_frame_arbiter: directed TX/RX sequences, an RX vector table,
// and randomized TX/RX traffic against a transaction-level reference model.
module tb_spi_frame_arbiter;
   localparam int HOLD = 64;

   logic CLK;
   logic RESET_N;
   int   errors;
   int   checks;
   logic [247:0] pay [4];

   spi_frame_arbiter_if bus ();

   spi_frame_arbiter #(.HOLD_CYCLES(HOLD)) dut (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .bus    (bus.slave)
   );

   assign bus.TX_DATA = {pay[3], pay[2], pay[1], pay[0]};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic         wr;
      logic [7:0]   hdr;
      logic [247:0] pld;
      logic [3:0]   rdy;
      logic [3:0]   exp_valid;
      logic [247:0] exp_data;
      logic [7:0]   exp_drop;
   } rx_vec_t;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [247:0] rand248();
      logic [255:0] t;
      for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
      return t[247:0];
   endfunction

   function automatic int first_from(input logic [3:0] m, input int p);
      for (int i = 0; i < 4; i++) if (m[(p + i) % 4]) return (p + i) % 4;
      return -1;
   endfunction

   task automatic clear_inputs();
      bus.HOST_DATA_READ  = 1'b0;
      bus.HOST_DATA_WRITE = 1'b0;
      bus.HOST_DATA_OUT   = '0;
      bus.TX_REQ          = 4'b0000;
      bus.RX_READY        = 4'b0000;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      clear_inputs();
      tick();
      tick();
      RESET_N = 1'b1;
   endtask

   // Pulses HOST_DATA_READ now and watches the whole hold window; the acked client drops its
   // request on its ack. extra_at>0 injects a second read plus a routed RX write mid-hold.
   task automatic do_read(input string nm, input logic [255:0] exp_frame,
                          input logic [3:0] exp_ack, input int extra_at);
      int           ack_at;
      int           nacks;
      bit           stable;
      logic [3:0]   mask;
      logic [247:0] p;
      ack_at = 0;
      nacks  = 0;
      stable = 1'b1;
      mask   = 4'b0000;
      p      = rand248();
      chk({nm, " frame before read"}, bus.HOST_DATA_IN, exp_frame);
      chk({nm, " busy before read"}, 256'(bus.BUSY), 256'(exp_ack != 4'b0000));
      bus.HOST_DATA_READ = 1'b1;
      tick();
      bus.HOST_DATA_READ = 1'b0;
      for (int c = 1; c <= HOLD; c++) begin
         if (bus.HOST_DATA_IN !== exp_frame || bus.BUSY !== 1'b1) stable = 1'b0;
         if (bus.TX_ACK != 4'b0000) begin
            nacks++;
            if (ack_at == 0) begin
               ack_at = c;
               mask   = bus.TX_ACK;
            end
            bus.TX_REQ = bus.TX_REQ & ~bus.TX_ACK;
         end
         if (extra_at != 0 && c == extra_at + 1) begin
            chk({nm, " mid-hold rx_valid"}, 256'(bus.RX_VALID), 256'(4'b0010));
            chk({nm, " mid-hold rx_data"}, 256'(bus.RX_DATA), 256'(p));
            bus.HOST_DATA_READ  = 1'b0;
            bus.HOST_DATA_WRITE = 1'b0;
            bus.RX_READY        = 4'b0000;
         end
         if (extra_at != 0 && c == extra_at) begin
            bus.HOST_DATA_READ  = 1'b1;
            bus.HOST_DATA_WRITE = 1'b1;
            bus.HOST_DATA_OUT   = {p, 8'h81};
            bus.RX_READY        = 4'b0010;
         end
         tick();
      end
      chk({nm, " frame stable in hold"}, 256'(stable), 256'(1));
      chk({nm, " ack count"}, 256'(nacks), 256'(exp_ack != 4'b0000));
      chk({nm, " ack cycle"}, 256'(ack_at), 256'((exp_ack != 4'b0000) ? HOLD : 0));
      chk({nm, " ack mask"}, 256'(mask), 256'(exp_ack));
      chk({nm, " frame after hold"}, bus.HOST_DATA_IN, '0);
      chk({nm, " busy after hold"}, 256'(bus.BUSY), 256'(0));
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " host_data_in"}, bus.HOST_DATA_IN, '0);
      chk({nm, " tx_ack"}, 256'(bus.TX_ACK), '0);
      chk({nm, " rx_valid"}, 256'(bus.RX_VALID), '0);
      chk({nm, " rx_data"}, 256'(bus.RX_DATA), '0);
      chk({nm, " busy"}, 256'(bus.BUSY), '0);
      chk({nm, " drop_cnt"}, 256'(bus.DROP_CNT), '0);
   endtask

   initial begin
      rx_vec_t      vecs [7];
      logic [247:0] pa;
      logic [247:0] pv [7];
      logic [3:0]   pending;
      int           mptr;
      logic [3:0]   m_valid;
      logic [247:0] m_data;
      int           m_drop;

      errors = 0;
      checks = 0;
      for (int k = 0; k < 4; k++) pay[k] = '0;

      do_reset();
      chk_all_zero("reset");

      // Single client 2 frame, full hold window.
      pa      = rand248();
      pay[2]  = pa;
      bus.TX_REQ = 4'b0100;
      tick();
      chk("stage c2 busy", 256'(bus.BUSY), 256'(1));
      do_read("c2", {pa, 8'h82}, 4'b0100, 0);

      // Round-robin order from pointer 0.
      do_reset();
      for (int k = 0; k < 4; k++) pay[k] = rand248();
      bus.TX_REQ = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         tick();
         do_read($sformatf("rr c%0d", k), {pay[k], 1'b1, 5'b0, 2'(k)}, 4'(1 << k), 0);
      end
      chk("rr all dropped", 256'(bus.TX_REQ), '0);
      bus.TX_REQ = 4'b1001;
      tick();
      do_read("rr again c0", {pay[0], 8'h80}, 4'b0001, 0);
      tick();
      do_read("rr again c3", {pay[3], 8'h83}, 4'b1000, 0);

      // Read in idle wins over a same-cycle request; client 1 staged right after.
      pay[1] = rand248();
      bus.TX_REQ = 4'b0010;
      do_read("empty", '0, 4'b0000, 0);
      tick();
      do_read("after empty c1", {pay[1], 8'h81}, 4'b0010, 0);

      // Asynchronous reset in the middle of a hold.
      pa = rand248();
      bus.HOST_DATA_WRITE = 1'b1;
      bus.HOST_DATA_OUT   = {pa, 8'h83};
      bus.RX_READY        = 4'b1000;
      tick();
      bus.RX_READY = 4'b0000;
      tick();
      bus.HOST_DATA_WRITE = 1'b0;
      chk("pre-reset drop_cnt", 256'(bus.DROP_CNT), 256'(1));
      chk("pre-reset rx_data", 256'(bus.RX_DATA), 256'(pa));
      pay[2] = rand248();
      bus.TX_REQ = 4'b0100;
      tick();
      bus.HOST_DATA_READ = 1'b1;
      tick();
      bus.HOST_DATA_READ = 1'b0;
      repeat (20) tick();
      chk("mid-hold busy", 256'(bus.BUSY), 256'(1));
      RESET_N = 1'b0;
      #1;
      chk_all_zero("async reset");
      tick();
      tick();
      chk("reset held tx_ack", 256'(bus.TX_ACK), '0);
      RESET_N = 1'b1;
      tick();
      do_read("re-served c2", {pay[2], 8'h82}, 4'b0100, 0);

      // Second read and a simultaneous write during hold.
      pay[0] = rand248();
      bus.TX_REQ = 4'b0001;
      tick();
      do_read("second read", {pay[0], 8'h80}, 4'b0001, 10);

      // RX vector table.
      do_reset();
      for (int i = 0; i < 7; i++) pv[i] = rand248();
      vecs[0] = '{1'b1, 8'h83, pv[0], 4'b1000, 4'b1000, pv[0], 8'd0};
      vecs[1] = '{1'b1, 8'h83, pv[1], 4'b0000, 4'b0000, pv[0], 8'd1};
      vecs[2] = '{1'b1, 8'h03, pv[2], 4'b1111, 4'b0000, pv[0], 8'd1};
      vecs[3] = '{1'b0, 8'h80, pv[3], 4'b1111, 4'b0000, pv[0], 8'd1};
      vecs[4] = '{1'b1, 8'h80, pv[4], 4'b0001, 4'b0001, pv[4], 8'd1};
      vecs[5] = '{1'b1, 8'hFD, pv[5], 4'b0010, 4'b0010, pv[5], 8'd1};
      vecs[6] = '{1'b1, 8'h82, pv[6], 4'b1011, 4'b0000, pv[5], 8'd2};
      for (int i = 0; i < 7; i++) begin
         bus.HOST_DATA_WRITE = vecs[i].wr;
         bus.HOST_DATA_OUT   = {vecs[i].pld, vecs[i].hdr};
         bus.RX_READY        = vecs[i].rdy;
         tick();
         chk($sformatf("rxvec%0d valid", i), 256'(bus.RX_VALID), 256'(vecs[i].exp_valid));
         chk($sformatf("rxvec%0d data", i), 256'(bus.RX_DATA), 256'(vecs[i].exp_data));
         chk($sformatf("rxvec%0d drop", i), 256'(bus.DROP_CNT), 256'(vecs[i].exp_drop));
      end
      bus.HOST_DATA_WRITE = 1'b0;
      tick();
      chk("rx valid one cycle", 256'(bus.RX_VALID), '0);
      chk("rx data held", 256'(bus.RX_DATA), 256'(pv[5]));

      // Drop counter saturation.
      bus.HOST_DATA_WRITE = 1'b1;
      bus.HOST_DATA_OUT   = {pv[1], 8'h83};
      bus.RX_READY        = 4'b0000;
      repeat (300) tick();
      bus.HOST_DATA_WRITE = 1'b0;
      tick();
      chk("drop saturates", 256'(bus.DROP_CNT), 256'(255));

      // Random RX traffic.
      do_reset();
      m_data = '0;
      m_drop = 0;
      for (int i = 0; i < 300; i++) begin
         logic       wr;
         logic [7:0] hdr;
         logic [3:0] rdy;
         logic [247:0] pl;
         wr  = 1'($urandom_range(0, 1));
         hdr = 8'($urandom);
         rdy = 4'($urandom);
         pl  = rand248();
         bus.HOST_DATA_WRITE = wr;
         bus.HOST_DATA_OUT   = {pl, hdr};
         bus.RX_READY        = rdy;
         m_valid = 4'b0000;
         if (wr && hdr[7]) begin
            if (rdy[hdr[1:0]]) begin
               m_valid = 4'(1 << hdr[1:0]);
               m_data  = pl;
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end
         tick();
         chk("rnd rx valid", 256'(bus.RX_VALID), 256'(m_valid));
         chk("rnd rx data", 256'(bus.RX_DATA), 256'(m_data));
         chk("rnd drop", 256'(bus.DROP_CNT), 256'(m_drop));
      end

      // Random TX traffic: pending set plus round-robin pointer model.
      do_reset();
      pending = 4'b0000;
      mptr    = 0;
      for (int it = 0; it < 30; it++) begin
         logic [3:0] nw;
         int         k;
         nw = 4'($urandom_range(0, 15)) & ~pending;
         for (int j = 0; j < 4; j++) if (nw[j]) pay[j] = rand248();
         pending    = pending | nw;
         bus.TX_REQ = pending;
         if (pending == 4'b0000 || $urandom_range(0, 4) == 0) begin
            do_read("rnd empty", '0, 4'b0000, 0);
         end else begin
            k = first_from(pending, mptr);
            tick();
            do_read($sformatf("rnd tx c%0d", k), {pay[k], 1'b1, 5'b0, 2'(k)}, 4'(1 << k), 0);
            pending[k] = 1'b0;
            mptr       = (k + 1) % 4;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
